// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_pkg
// Brief   : Shared widths and load/writeback FSM state type for the CPU core.
// Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 2 ** REG_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } lwb_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/lwb_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : lwb_cmd_fifo
// Brief  : Synchronous FIFO of pending load commands {dest, addr}. Exposes the
//          per-slot valid bits and dest fields so the owner can build a
//          register-busy mask over everything still queued.
// Rev    : 1.0  initial release
// ============================================================================
module lwb_cmd_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int DEST_W  = cpu_pkg::REG_AW,
  parameter int CADDR_W = cpu_pkg::ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic [DEST_W-1:0]             i_push_dest,
  input  logic [CADDR_W-1:0]            i_push_addr,
  input  logic                          i_pop,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [DEST_W-1:0]             o_head_dest,
  output logic [CADDR_W-1:0]            o_head_addr,
  output logic [DEPTH-1:0]              o_entry_vld,
  output logic [DEPTH-1:0][DEST_W-1:0]  o_entry_dest
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [DEPTH-1:0]   r_vld;
  logic [DEST_W-1:0]  r_dest [DEPTH];
  logic [CADDR_W-1:0] r_addr [DEPTH];
  logic               w_push_ok;
  logic               w_pop_ok;

  // Slots fill and drain strictly in ring order, so the slot under each
  // pointer tells us full/empty without a separate occupancy counter.
  assign o_full      = r_vld[r_wr_ptr];
  assign o_empty     = ~r_vld[r_rd_ptr];
  assign w_push_ok   = i_push & ~o_full;
  assign w_pop_ok    = i_pop & ~o_empty;
  assign o_head_dest = r_dest[r_rd_ptr];
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_entry_vld = r_vld;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign o_entry_dest[gi] = r_dest[gi];
  end

  // Pointer and slot-valid bookkeeping; a push and a pop never hit the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_vld    <= '0;
    end else begin
      if (w_push_ok) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Payload storage; contents are only observed through valid slots.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_dest[r_wr_ptr] <= i_push_dest;
      r_addr[r_wr_ptr] <= i_push_addr;
    end
  end

endmodule : lwb_cmd_fifo
`default_nettype wire

// File: rtl/load_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module : load_writeback_ctrl
// Brief  : Queues LOAD commands, reads the operand from data RAM via req/ack,
//          and writes it into the register file for exactly one cycle. Tracks
//          registers with loads in flight and times out reads that never ack.
// Rev    : 1.0  initial release
// ============================================================================
module load_writeback_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int REG_AW      = cpu_pkg::REG_AW,
  parameter int QDEPTH      = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [REG_AW-1:0]      i_cmd_dest,
  input  logic [ADDR_W-1:0]      i_cmd_addr,
  output logic                   o_mem_req,
  output logic [ADDR_W-1:0]      o_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [DATA_W-1:0]      i_mem_rdata,
  output logic                   o_write_enable,
  output logic [REG_AW-1:0]      o_write_addr,
  output logic [DATA_W-1:0]      o_write_data,
  output logic [2**REG_AW-1:0]   o_busy_mask,
  output logic                   o_timeout_err,
  input  logic                   i_err_clr
);

  localparam int NREG = 2 ** REG_AW;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  lwb_state_t                     r_state;
  lwb_state_t                     w_next;
  logic                           w_pop;
  logic                           w_capture;
  logic                           w_timeout;
  logic                           w_fifo_full;
  logic                           w_fifo_empty;
  logic [REG_AW-1:0]              w_head_dest;
  logic [ADDR_W-1:0]              w_head_addr;
  logic [QDEPTH-1:0]              w_ent_vld;
  logic [QDEPTH-1:0][REG_AW-1:0]  w_ent_dest;
  logic [NREG-1:0]                w_busy;
  logic [REG_AW-1:0]              r_dest;
  logic [ADDR_W-1:0]              r_mem_addr;
  logic [TW-1:0]                  r_timer;
  logic                           r_we;
  logic [REG_AW-1:0]              r_waddr;
  logic [DATA_W-1:0]              r_wdata;
  logic                           r_err;

  lwb_cmd_fifo #(
    .DEPTH   (QDEPTH),
    .DEST_W  (REG_AW),
    .CADDR_W (ADDR_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (i_cmd_valid),
    .i_push_dest  (i_cmd_dest),
    .i_push_addr  (i_cmd_addr),
    .i_pop        (w_pop),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_head_dest  (w_head_dest),
    .o_head_addr  (w_head_addr),
    .o_entry_vld  (w_ent_vld),
    .o_entry_dest (w_ent_dest)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; ack takes priority over an expiring timer.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop  = 1'b1;
          w_next = REQ;
        end
      end
      REQ: begin
        if (i_mem_ack) begin
          w_capture = 1'b1;
          w_next    = WB;
        end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      WB: begin
        if (!w_fifo_empty) begin
          w_pop  = 1'b1;
          w_next = REQ;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Load the in-flight command on pop and age the request while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dest     <= '0;
      r_mem_addr <= '0;
      r_timer    <= '0;
    end else if (w_pop) begin
      r_dest     <= w_head_dest;
      r_mem_addr <= w_head_addr;
      r_timer    <= '0;
    end else if (r_state == REQ) begin
      r_timer    <= r_timer + TW'(1);
    end
  end

  // Register-file write port: one-cycle strobe, index/data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_capture;
      if (w_capture) begin
        r_waddr <= r_dest;
        r_wdata <= i_mem_rdata;
      end
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  // Busy mask: every queued dest plus the dest of the load in REQ/WB.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (w_ent_vld[i]) begin
        w_busy[w_ent_dest[i]] = 1'b1;
      end
    end
    if (r_state != IDLE) begin
      w_busy[r_dest] = 1'b1;
    end
  end

  assign o_cmd_ready    = ~w_fifo_full;
  assign o_mem_req      = (r_state == REQ);
  assign o_mem_addr     = r_mem_addr;
  assign o_write_enable = r_we;
  assign o_write_addr   = r_waddr;
  assign o_write_data   = r_wdata;
  assign o_busy_mask    = w_busy;
  assign o_timeout_err  = r_err;

endmodule : load_writeback_ctrl
`default_nettype wire
